// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-stream, host handshake and payload read port of the UART frame controller.
// The master side is the surrounding system; the slave side is the controller.
interface uart_rx_frame_ctrl_if #(
    parameter int MAX_LEN = 16
);
    localparam int ADDR_W = $clog2(MAX_LEN);

    logic [7:0]        rx_data;
    logic              rx_rdy;
    logic              bd8_rate;
    logic              frame_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              frame_valid;
    logic [7:0]        frame_len;
    logic              busy;
    logic              err;
    logic [2:0]        err_code;

    modport master (
        output rx_data, rx_rdy, bd8_rate, frame_ack, rd_addr,
        input  rd_data, frame_valid, frame_len, busy, err, err_code
    );

    modport slave (
        input  rx_data, rx_rdy, bd8_rate, frame_ack, rd_addr,
        output rd_data, frame_valid, frame_len, busy, err, err_code
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind an 8x oversampled UART receiver: delineates SOF/LEN/payload/CHK
// frames, buffers the payload and holds a validated frame until the host acknowledges it.
module uart_rx_frame_ctrl #(
    parameter int         MAX_LEN = 16,
    parameter logic [7:0] SOF     = 8'hA5,
    parameter int         TIMEOUT = 160
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_rx_frame_ctrl_if.slave   bus
);
    localparam int ADDR_W = $clog2(MAX_LEN);
    localparam int IDX_W  = $clog2(MAX_LEN + 1);
    localparam int TW     = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, HOLD} state_t;

    state_t          state_q;
    logic [7:0]      len_q;
    logic [7:0]      chk_q;
    logic [IDX_W-1:0] idx_q;
    logic [TW-1:0]   tmo_q;
    logic [7:0]      frame_len_q;
    logic            frame_valid_q;
    logic            busy_q;
    logic            err_q;
    logic [2:0]      err_code_q;
    logic [7:0]      rd_data_q;
    logic [7:0]      buf_q [MAX_LEN];

    logic       buf_we;
    logic [7:0] idx_inc;

    assign buf_we  = (state_q == PAYLOAD) && bus.rx_rdy;
    assign idx_inc = 8'(idx_q) + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            len_q         <= '0;
            chk_q         <= '0;
            idx_q         <= '0;
            tmo_q         <= '0;
            frame_len_q   <= '0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (bus.rx_rdy && bus.rx_data == SOF) begin
                        state_q <= LEN;
                        busy_q  <= 1'b1;
                        tmo_q   <= '0;
                    end
                end
                LEN, PAYLOAD, CHK: begin
                    // A byte always wins over a simultaneous timebase tick.
                    if (bus.rx_rdy) begin
                        tmo_q <= '0;
                        if (state_q == LEN) begin
                            if (bus.rx_data != 8'd0 && bus.rx_data <= MAX_LEN_B) begin
                                len_q   <= bus.rx_data;
                                chk_q   <= bus.rx_data;
                                idx_q   <= '0;
                                state_q <= PAYLOAD;
                            end else begin
                                err_q      <= 1'b1;
                                err_code_q <= 3'd1;
                                state_q    <= HUNT;
                                busy_q     <= 1'b0;
                            end
                        end else if (state_q == PAYLOAD) begin
                            chk_q <= chk_q ^ bus.rx_data;
                            idx_q <= idx_q + IDX_W'(1);
                            if (idx_inc == len_q) begin
                                state_q <= CHK;
                            end
                        end else begin
                            busy_q <= 1'b0;
                            if (bus.rx_data == chk_q) begin
                                frame_len_q   <= len_q;
                                frame_valid_q <= 1'b1;
                                state_q       <= HOLD;
                            end else begin
                                err_q      <= 1'b1;
                                err_code_q <= 3'd2;
                                state_q    <= HUNT;
                            end
                        end
                    end else if (bus.bd8_rate) begin
                        if (tmo_q == TMO_LAST) begin
                            err_q      <= 1'b1;
                            err_code_q <= 3'd3;
                            state_q    <= HUNT;
                            busy_q     <= 1'b0;
                            tmo_q      <= '0;
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                end
                HOLD: begin
                    // An ack releases the frame and lets a coincident byte be hunted normally.
                    if (bus.frame_ack) begin
                        frame_valid_q <= 1'b0;
                        if (bus.rx_rdy && bus.rx_data == SOF) begin
                            state_q <= LEN;
                            busy_q  <= 1'b1;
                            tmo_q   <= '0;
                        end else begin
                            state_q <= HUNT;
                        end
                    end else if (bus.rx_rdy) begin
                        err_q      <= 1'b1;
                        err_code_q <= 3'd4;
                    end
                end
                default: begin
                    state_q <= HUNT;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[idx_q[ADDR_W-1:0]] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= buf_q[bus.rd_addr];
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_len   = frame_len_q;
    assign bus.busy        = busy_q;
    assign bus.err         = err_q;
    assign bus.err_code    = err_code_q;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: stimulus pushes expected frame/error events into a
// queue that a negedge monitor pops and compares; timing and readback are checked inline.
module tb_uart_rx_frame_ctrl;
    localparam int MAX_LEN = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_frame_ctrl_if #(.MAX_LEN(MAX_LEN)) bus ();

    uart_rx_frame_ctrl #(
        .MAX_LEN(MAX_LEN),
        .SOF    (8'hA5),
        .TIMEOUT(160)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        bit         is_frame;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errs   = 0;
    bit   fv_prev  = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic expect_evt(input bit is_frame, input logic [7:0] val);
        exp_t e;
        e.is_frame = is_frame;
        e.val      = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input bit is_frame, input logic [7:0] val);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errs++;
            $display("FAIL unexpected_%s: got %0h, expected no event", is_frame ? "frame" : "err", val);
        end else begin
            e = exp_q.pop_front();
            if (e.is_frame != is_frame || e.val != val) begin
                n_errs++;
                $display("FAIL event: got %s %0h, expected %s %0h",
                         is_frame ? "frame" : "err", val, e.is_frame ? "frame" : "err", e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            fv_prev = 1'b0;
        end else begin
            if (bus.err) begin
                $display("[%0t] err code=%0d", $time, bus.err_code);
                pop_cmp(1'b0, {5'd0, bus.err_code});
            end
            if (bus.frame_valid && !fv_prev) begin
                $display("[%0t] frame len=%0d", $time, bus.frame_len);
                pop_cmp(1'b1, bus.frame_len);
            end
            fv_prev = bus.frame_valid;
        end
    end

    // All tasks start and end 1 time unit after a rising edge, so bytes can be back-to-back.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        @(posedge clk); #1;
        bus.rx_rdy  = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            bus.bd8_rate = 1'b1;
            @(posedge clk); #1;
            bus.bd8_rate = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic read_chk(input logic [3:0] a, input logic [7:0] req, input string nm);
        bus.rd_addr = a;
        @(posedge clk); #1;
        check(nm, bus.rd_data, req);
    endtask

    task automatic ack();
        bus.frame_ack = 1'b1;
        @(posedge clk); #1;
        bus.frame_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_data   = '0;
        bus.rx_rdy    = 1'b0;
        bus.bd8_rate  = 1'b0;
        bus.frame_ack = 1'b0;
        bus.rd_addr   = '0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        check("rst_frame_valid", bus.frame_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err_code", bus.err_code, 0);
        check("rst_frame_len", bus.frame_len, 0);
        check("rst_rd_data", bus.rd_data, 0);

        // Good frame A5 03 11 22 33 03, bytes back-to-back.
        expect_evt(1'b1, 8'd3);
        send_byte(8'hA5);
        check("busy_after_sof", bus.busy, 1);
        send_seq('{8'h03, 8'h11, 8'h22, 8'h33});
        check("fv_before_chk", bus.frame_valid, 0);
        send_byte(8'h03);
        check("fv_after_chk", bus.frame_valid, 1);
        check("good_len", bus.frame_len, 3);
        read_chk(4'd0, 8'h11, "rd0");
        read_chk(4'd1, 8'h22, "rd1");
        read_chk(4'd2, 8'h33, "rd2");

        // Overrun while held.
        expect_evt(1'b0, 8'd4);
        send_byte(8'h55);
        check("ovr_err", bus.err, 1);
        check("ovr_fv", bus.frame_valid, 1);
        check("ovr_len", bus.frame_len, 3);
        read_chk(4'd1, 8'h22, "ovr_rd1");

        // Ack colliding with SOF starts the next frame.
        bus.frame_ack = 1'b1;
        bus.rx_data   = 8'hA5;
        bus.rx_rdy    = 1'b1;
        @(posedge clk); #1;
        bus.frame_ack = 1'b0;
        bus.rx_rdy    = 1'b0;
        check("ack_fv_low", bus.frame_valid, 0);
        check("ack_sof_busy", bus.busy, 1);
        expect_evt(1'b1, 8'd1);
        send_seq('{8'h01, 8'h7E, 8'h7F});
        check("f2_fv", bus.frame_valid, 1);
        check("f2_len", bus.frame_len, 1);
        read_chk(4'd0, 8'h7E, "f2_rd0");
        ack();
        check("ack_clears_fv", bus.frame_valid, 0);
        idle(2);

        // Bad checksum.
        expect_evt(1'b0, 8'd2);
        send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04});
        check("badchk_err", bus.err, 1);
        idle(1);
        check("badchk_fv", bus.frame_valid, 0);
        check("badchk_busy", bus.busy, 0);
        check("badchk_code_hold", bus.err_code, 2);

        // Bad lengths, with silently discarded junk in front of the second.
        expect_evt(1'b0, 8'd1);
        send_seq('{8'hA5, 8'h00});
        idle(2);
        check("len0_busy", bus.busy, 0);
        expect_evt(1'b0, 8'd1);
        send_seq('{8'h00, 8'hFF, 8'hA5, 8'h11});
        idle(1);
        check("len17_code", bus.err_code, 1);
        check("len17_busy", bus.busy, 0);

        // Timeout: a byte on tick 159 restarts the count; expiry on the 160th tick.
        send_seq('{8'hA5, 8'h02, 8'h11});
        ticks(159);
        check("tmo_not_yet", bus.busy, 1);
        bus.rx_data  = 8'h22;
        bus.rx_rdy   = 1'b1;
        bus.bd8_rate = 1'b1;
        @(posedge clk); #1;
        bus.rx_rdy   = 1'b0;
        bus.bd8_rate = 1'b0;
        idle(1);
        ticks(159);
        check("tmo_159_busy", bus.busy, 1);
        check("tmo_159_err", bus.err, 0);
        expect_evt(1'b0, 8'd3);
        bus.bd8_rate = 1'b1;
        @(posedge clk); #1;
        bus.bd8_rate = 1'b0;
        check("tmo_err", bus.err, 1);
        check("tmo_code", bus.err_code, 3);
        check("tmo_busy", bus.busy, 0);
        idle(2);

        // Reset mid-frame, then a good frame A5 02 AB CD 64.
        send_seq('{8'hA5, 8'h03, 8'h11});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_busy", bus.busy, 0);
        check("mrst_err", bus.err, 0);
        check("mrst_code", bus.err_code, 0);
        check("mrst_len", bus.frame_len, 0);
        check("mrst_rd", bus.rd_data, 0);
        expect_evt(1'b1, 8'd2);
        send_seq('{8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h64});
        check("f3_fv", bus.frame_valid, 1);
        read_chk(4'd0, 8'hAB, "f3_rd0");
        read_chk(4'd1, 8'hCD, "f3_rd1");
        ack();
        idle(5);

        check("pending_events", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
